// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_pkg
//  Description : Shared types and constants for the req/ack clock-domain
//                crossing blocks (receiver FSM states, synchronizer depth).
//  Revision    : 1.0  initial release
// ============================================================================
package cdc_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_VALID = 2'd1,
        RX_ACK   = 2'd2
    } rx_state_e;

    // Fewer than two flops does not give metastability time to resolve.
    localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/cdc_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_sync
//  Description : N-flop level synchronizer with asynchronous active-low
//                reset. Every stage resets to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module cdc_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Stage 0 is the metastable capture flop; stage STAGES-1 is the output.
    logic [STAGES-1:0][W-1:0] r_q;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else begin
            r_q <= {r_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_q[STAGES-1];

endmodule : cdc_sync
`default_nettype wire

// File: rtl/cdc_handshake_rx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_handshake_rx
//  Description : Receiving endpoint of a four-phase req/ack crossing. The
//                request level is synchronized, the quasi-static data bus is
//                captured once per request, offered locally via valid/ready,
//                and a flop-driven acknowledge level is returned.
//  Revision    : 1.0  initial release
// ============================================================================
module cdc_handshake_rx
    import cdc_pkg::*;
#(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_async_i,
    input  logic [W-1:0] data_async_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         ack_o,
    output logic         busy_o
);

    localparam logic [1:0] c_ST_IDLE  = RX_IDLE;
    localparam logic [1:0] c_ST_VALID = RX_VALID;
    localparam logic [1:0] c_ST_ACK   = RX_ACK;

    // Refuse to build a synchronizer too short to be safe.
    generate
        if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync_stages
            $error("cdc_handshake_rx: SYNC_STAGES must be at least %0d", CDC_MIN_SYNC_STAGES);
        end
    endgenerate

    logic         w_req_sync;
    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic         w_capture;
    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_ack;
    logic         r_busy;

    cdc_sync #(
        .W      (1),
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (req_async_i),
        .q_o    (w_req_sync)
    );

    // Next-state logic; capture happens only on the IDLE->VALID transition,
    // so the data bus is sampled once per request while it is guaranteed stable.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req_sync) begin
                    w_state_next = c_ST_VALID;
                    w_capture    = 1'b1;
                end
            end
            c_ST_VALID: begin
                if (ready_i) begin
                    w_state_next = c_ST_ACK;
                end
            end
            c_ST_ACK: begin
                // Wait for the sender to drop req before a new capture is allowed.
                if (!w_req_sync) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // State register plus flop-registered decodes so no output is combinational.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= (w_state_next == c_ST_VALID);
            r_ack   <= (w_state_next == c_ST_ACK);
            r_busy  <= (w_state_next != c_ST_IDLE);
        end
    end

    // Data holding register, loaded only on capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
        end else if (w_capture) begin
            r_data <= data_async_i;
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign ack_o   = r_ack;
    assign busy_o  = r_busy;

endmodule : cdc_handshake_rx
`default_nettype wire
